// File: rtl/gcd.sv
// Iterative GCD unit: Euclid's subtraction algorithm over a register/mux/ALU
// datapath, with operands delivered over a shared bus by a four-phase
// req/ack handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for req to deliver operand A
// ACK_A  | A captured, ack high until host drops req
// WAIT_B | waiting for req to deliver operand B
// CMP    | one compare/subtract decision per cycle
// ACK_C  | result on C, ack high until host drops req
module gcd #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req,
   input  logic [N-1:0] AB,
   output logic         ack,
   output logic [N-1:0] C
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACK_A  = 3'd1,
      WAIT_B = 3'd2,
      CMP    = 3'd3,
      ACK_C  = 3'd4
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [N-1:0] c_q, c_d;
   logic         ack_q, ack_d;

   logic [N-1:0] alu_diff;
   logic [N-1:0] alu_ndiff;
   logic         alu_z;
   logic         alu_n;
   logic         a_zero;
   logic         b_zero;
   logic         out_of_range;

   // ALU: A_r - B_r with zero and negative flags. With both operands below
   // 2^(N-1), the sign bit of the difference is an exact unsigned A < B.
   // B_r - A_r is the two's-complement negation of the same difference.
   always_comb begin
      alu_diff     = a_q - b_q;
      alu_ndiff    = ~alu_diff + {{(N-1){1'b0}}, 1'b1};
      alu_z        = (alu_diff == '0);
      alu_n        = alu_diff[N-1];
      a_zero       = (a_q == '0);
      b_zero       = (b_q == '0);
      out_of_range = a_q[N-1] | b_q[N-1];
   end

   // Next-state, register-load mux selects and acknowledge.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               a_d     = AB;
               state_d = ACK_A;
            end
         end
         ACK_A: begin
            if (!req) state_d = WAIT_B;
         end
         WAIT_B: begin
            if (req) begin
               b_d     = AB;
               state_d = CMP;
            end
         end
         CMP: begin
            // req is deliberately not looked at here: a host that drops req
            // mid-computation still gets the result, for a single cycle.
            if (out_of_range) begin
               c_d     = '0;
               state_d = ACK_C;
            end else if (a_zero) begin
               c_d     = b_q;
               state_d = ACK_C;
            end else if (b_zero) begin
               c_d     = a_q;
               state_d = ACK_C;
            end else if (alu_z) begin
               c_d     = a_q;
               state_d = ACK_C;
            end else if (alu_n) begin
               b_d = alu_ndiff;
            end else begin
               a_d = alu_diff;
            end
         end
         ACK_C: begin
            if (!req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ack_d = (state_d == ACK_A) || (state_d == ACK_C);
   end

   // State and datapath registers; synchronous reset discards any in-flight work.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         ack_q   <= ack_d;
      end
   end

   assign ack = ack_q;
   assign C   = c_q;

endmodule
